fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirects, return-address stack and interrupt entry/exit.
// Optional interrupt logic (IE, EPC, accept, RTI) is built only when FETCH_IRQ_EN is defined.
module fetch_unit #(
    parameter logic [11:0] RESET_VECTOR = 12'h000,
    parameter logic [11:0] INT_VECTOR   = 12'h001,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [11:0] imem_adr,
    input  logic [15:0] imem_data,
    output logic [15:0] IR,
    output logic [11:0] PC,
    output logic [11:0] RTS_adr,
    input  logic        branch_taken,
    input  logic [11:0] branch_target,
    input  logic        subroutine_call,
    input  logic [11:0] call_target,
    input  logic        subroutine_return,
    input  logic        IEN,
    input  logic        IOF,
    input  logic        RTI,
    input  logic        irq,
    output logic        irq_ack,
    output logic        int_active,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    localparam int unsigned AW    = 12;
    localparam int unsigned IW    = 16;
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [IW-1:0]    NOP  = '0;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    rts_adr_q, rts_adr_d;
    logic [AW-1:0]    stack_q [RAS_DEPTH];
    logic [AW-1:0]    stack_d [RAS_DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             rti_go;
    logic             irq_go;
    logic [AW-1:0]    epc_w;
    logic             take_rti;
    logic             take_irq;

    assign imem_adr      = fetch_pc_q;
    assign IR            = ir_q;
    assign PC            = pc_q;
    assign RTS_adr       = rts_adr_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign irq_ack       = take_irq;

    // Priority decode of redirects and next-state for fetch, IR, PC and the return stack.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        stack_d    = stack_q;
        tos_d      = tos_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        take_rti   = 1'b0;
        take_irq   = 1'b0;

        if (!stall) begin
            if (rti_go) begin
                take_rti   = 1'b1;
                fetch_pc_d = epc_w;
                ir_d       = NOP;
            end else if (subroutine_return) begin
                ir_d = NOP;
                if (cnt_q != '0) begin
                    fetch_pc_d = rts_adr_q;
                    tos_d      = tos_q - PTR_W'(1);
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    fetch_pc_d = '0;
                    unf_d      = 1'b1;
                end
            end else if (subroutine_call) begin
                // Full stack wraps onto the oldest entry; depth saturates.
                tos_d          = tos_q + PTR_W'(1);
                stack_d[tos_d] = pc_q;
                if (cnt_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                fetch_pc_d = call_target;
                ir_d       = NOP;
            end else if (branch_taken) begin
                fetch_pc_d = branch_target;
                ir_d       = NOP;
            end else if (irq_go) begin
                take_irq   = 1'b1;
                fetch_pc_d = INT_VECTOR;
                ir_d       = NOP;
            end else begin
                ir_d       = imem_data;
                pc_d       = fetch_pc_q + AW'(1);
                fetch_pc_d = fetch_pc_q + AW'(1);
            end
        end

        rts_adr_d = (cnt_d == '0) ? '0 : stack_d[tos_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_VECTOR;
            ir_q       <= NOP;
            pc_q       <= '0;
            rts_adr_q  <= '0;
            tos_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            rts_adr_q  <= rts_adr_d;
            tos_q      <= tos_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            stack_q    <= stack_d;
        end
    end

`ifdef FETCH_IRQ_EN
    logic          ie_q, ie_d;
    logic          int_active_q, int_active_d;
    logic [AW-1:0] epc_q, epc_d;

    assign rti_go     = RTI & int_active_q;
    assign irq_go     = ie_q & irq & ~int_active_q;
    assign epc_w      = epc_q;
    assign int_active = int_active_q;

    // Interrupt enable and handler state; accept and RTI override IEN/IOF.
    always_comb begin
        ie_d         = ie_q;
        int_active_d = int_active_q;
        epc_d        = epc_q;
        if (!stall) begin
            if (IOF) begin
                ie_d = 1'b0;
            end else if (IEN) begin
                ie_d = 1'b1;
            end
            if (take_rti) begin
                ie_d         = 1'b1;
                int_active_d = 1'b0;
            end
            if (take_irq) begin
                ie_d         = 1'b0;
                int_active_d = 1'b1;
                epc_d        = fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q         <= 1'b0;
            int_active_q <= 1'b0;
            epc_q        <= '0;
        end else begin
            ie_q         <= ie_d;
            int_active_q <= int_active_d;
            epc_q        <= epc_d;
        end
    end
`else
    logic unused_irq_in;

    assign rti_go        = 1'b0;
    assign irq_go        = 1'b0;
    assign epc_w         = '0;
    assign int_active    = 1'b0;
    assign unused_irq_in = ^{irq, IEN, IOF, RTI};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/stall, nested calls, wrap, interrupts, reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [11:0] imem_adr;
    logic [15:0] imem_data;
    logic [15:0] IR;
    logic [11:0] PC;
    logic [11:0] RTS_adr;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        subroutine_call;
    logic [11:0] call_target;
    logic        subroutine_return;
    logic        IEN, IOF, RTI, irq;
    logic        irq_ack, int_active, ras_overflow, ras_underflow;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Memory image: mem[a] = a + 16'h1000
    assign imem_data = 16'h1000 + {4'h0, imem_adr};

    fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .imem_adr          (imem_adr),
        .imem_data         (imem_data),
        .IR                (IR),
        .PC                (PC),
        .RTS_adr           (RTS_adr),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .subroutine_call   (subroutine_call),
        .call_target       (call_target),
        .subroutine_return (subroutine_return),
        .IEN               (IEN),
        .IOF               (IOF),
        .RTI               (RTI),
        .irq               (irq),
        .irq_ack           (irq_ack),
        .int_active        (int_active),
        .ras_overflow      (ras_overflow),
        .ras_underflow     (ras_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [11:0] adr, input logic [15:0] ir,
                               input logic [11:0] pc);
        check({tag, ".adr"}, 32'(imem_adr), 32'(adr));
        check({tag, ".ir"},  32'(IR),       32'(ir));
        check({tag, ".pc"},  32'(PC),       32'(pc));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        subroutine_call = 1'b0; call_target = '0; subroutine_return = 1'b0;
        IEN = 1'b0; IOF = 1'b0; RTI = 1'b0; irq = 1'b0;
        step(); step();

        check_fetch("reset", 12'h000, 16'h0000, 12'h000);
        check("reset.rts",  32'(RTS_adr), 32'h0);
        check("reset.ack",  32'(irq_ack), 32'h0);
        check("reset.iact", 32'(int_active), 32'h0);
        check("reset.ovf",  32'(ras_overflow), 32'h0);
        check("reset.unf",  32'(ras_underflow), 32'h0);

        // Free run
        rst_n = 1'b1;
        step(); check_fetch("seq0", 12'h001, 16'h1000, 12'h001);
        step(); check_fetch("seq1", 12'h002, 16'h1001, 12'h002);
        step(); check_fetch("seq2", 12'h003, 16'h1002, 12'h003);
        step(); step(); check_fetch("seq4", 12'h005, 16'h1004, 12'h005);

        // Branch requested under stall: nothing moves
        branch_taken = 1'b1; branch_target = 12'h0A0; stall = 1'b1;
        step(); check_fetch("stall", 12'h005, 16'h1004, 12'h005);
        stall = 1'b0;
        step(); check_fetch("br.bubble", 12'h0A0, 16'h0000, 12'h005);
        branch_taken = 1'b0;
        step(); check_fetch("br.target", 12'h0A1, 16'h10A0, 12'h0A1);

        // Five nested calls, each followed by one sequential fetch
        for (int i = 0; i < 5; i++) begin
            logic [11:0] tgt, pushed;
            tgt    = 12'(12'h100 * (i + 1));
            pushed = (i == 0) ? 12'h0A1 : 12'(12'h100 * i + 1);
            subroutine_call = 1'b1; call_target = tgt;
            step();
            check($sformatf("call%0d.adr", i), 32'(imem_adr), 32'(tgt));
            check($sformatf("call%0d.ir", i),  32'(IR), 32'h0);
            check($sformatf("call%0d.rts", i), 32'(RTS_adr), 32'(pushed));
            check($sformatf("call%0d.ovf", i), 32'(ras_overflow), (i == 4) ? 32'h1 : 32'h0);
            subroutine_call = 1'b0;
            step();
            check_fetch($sformatf("call%0d.seq", i), tgt + 12'h001, 16'h1000 + {4'h0, tgt},
                        tgt + 12'h001);
        end

        // Four returns in LIFO order, then one from the empty stack
        subroutine_return = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("ret%0d.adr", j), 32'(imem_adr), 32'(12'(12'h100 * (4 - j) + 1)));
            check($sformatf("ret%0d.rts", j), 32'(RTS_adr),
                  (j < 3) ? 32'(12'(12'h100 * (3 - j) + 1)) : 32'h0);
            check($sformatf("ret%0d.unf", j), 32'(ras_underflow), 32'h0);
        end
        step();
        check_fetch("ret4", 12'h000, 16'h0000, 12'h501);
        check("ret4.unf", 32'(ras_underflow), 32'h1);
        check("ret4.ovf", 32'(ras_overflow), 32'h1);
        subroutine_return = 1'b0;
        step(); check_fetch("ret4.seq", 12'h001, 16'h1000, 12'h001);

        // Address wrap at 12'hFFF
        branch_taken = 1'b1; branch_target = 12'hFFE;
        step(); branch_taken = 1'b0;
        step(); check_fetch("wrap0", 12'hFFF, 16'h1FFE, 12'hFFF);
        step(); check_fetch("wrap1", 12'h000, 16'h1FFF, 12'h000);

`ifdef FETCH_IRQ_EN
        IEN = 1'b1;
        step(); IEN = 1'b0;
        step(); step(); check_fetch("pre_irq", 12'h003, 16'h1002, 12'h003);
        irq = 1'b1; #1;
        check("irq.ack", 32'(irq_ack), 32'h1);
        step();
        check_fetch("irq.entry", 12'h001, 16'h0000, 12'h003);
        check("irq.iact", 32'(int_active), 32'h1);
        check("irq2.ack", 32'(irq_ack), 32'h0);
        step(); check_fetch("irq.body", 12'h002, 16'h1001, 12'h002);
        irq = 1'b0; RTI = 1'b1;
        step();
        check_fetch("rti", 12'h003, 16'h0000, 12'h002);
        check("rti.iact", 32'(int_active), 32'h0);
        // Branch wins over an eligible irq; accept follows next cycle
        RTI = 1'b0; irq = 1'b1; branch_taken = 1'b1; branch_target = 12'h050; #1;
        check("brirq.ack0", 32'(irq_ack), 32'h0);
        step(); branch_taken = 1'b0;
        check("brirq.adr", 32'(imem_adr), 32'h050);
        #1; check("brirq.ack1", 32'(irq_ack), 32'h1);
        step();
        check("brirq.entry", 32'(imem_adr), 32'h001);
        check("brirq.iact", 32'(int_active), 32'h1);
        irq = 1'b0; RTI = 1'b1;
        step(); check("rti2.adr", 32'(imem_adr), 32'h050);
        // IOF beats IEN
        RTI = 1'b0; IEN = 1'b1; IOF = 1'b1;
        step(); check_fetch("ienof", 12'h051, 16'h1050, 12'h051);
        IEN = 1'b0; IOF = 1'b0; irq = 1'b1; #1;
        check("ienof.ack", 32'(irq_ack), 32'h0);
        step();
        check("ienof.adr", 32'(imem_adr), 32'h052);
        check("ienof.iact", 32'(int_active), 32'h0);
        // RTI outside a handler is a NOP
        irq = 1'b0; RTI = 1'b1;
        step(); check_fetch("rti_nop", 12'h053, 16'h1052, 12'h053);
        RTI = 1'b0;
`else
        IEN = 1'b1; irq = 1'b1; RTI = 1'b1; #1;
        check("noirq.ack", 32'(irq_ack), 32'h0);
        step();
        check_fetch("noirq", 12'h001, 16'h1000, 12'h001);
        check("noirq.iact", 32'(int_active), 32'h0);
        IEN = 1'b0; irq = 1'b0; RTI = 1'b0;
`endif

        // Mid-operation reset clears everything in one edge
        rst_n = 1'b0;
        step();
        check_fetch("rst2", 12'h000, 16'h0000, 12'h000);
        check("rst2.rts",  32'(RTS_adr), 32'h0);
        check("rst2.ovf",  32'(ras_overflow), 32'h0);
        check("rst2.unf",  32'(ras_underflow), 32'h0);
        check("rst2.iact", 32'(int_active), 32'h0);
        rst_n = 1'b1;
        step(); check_fetch("rst2.seq", 12'h001, 16'h1000, 12'h001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
